// File: rtl/ex_muldiv_unit_if.sv
// Issue-side bundle for the execute-stage mul/div unit: operand/op request plus HI/LO status.
interface ex_muldiv_unit_if;
   logic        start_ex_muldiv_i;
   logic [2:0]  op_ex_muldiv_i;
   logic [31:0] rs_data_ex_muldiv_i;
   logic [31:0] rt_data_ex_muldiv_i;
   logic        flush_ex_muldiv_i;
   logic        busy_ex_muldiv_o;
   logic        done_ex_muldiv_o;
   logic [31:0] hi_ex_muldiv_o;
   logic [31:0] lo_ex_muldiv_o;

   modport master (
      output start_ex_muldiv_i, op_ex_muldiv_i, rs_data_ex_muldiv_i, rt_data_ex_muldiv_i,
             flush_ex_muldiv_i,
      input  busy_ex_muldiv_o, done_ex_muldiv_o, hi_ex_muldiv_o, lo_ex_muldiv_o
   );

   modport slave (
      input  start_ex_muldiv_i, op_ex_muldiv_i, rs_data_ex_muldiv_i, rt_data_ex_muldiv_i,
             flush_ex_muldiv_i,
      output busy_ex_muldiv_o, done_ex_muldiv_o, hi_ex_muldiv_o, lo_ex_muldiv_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; restoring divider, fixed-latency multiply.
// MULDIV_EARLY_OUT_EN: divides with divisor 0 or |rs|<|rt| complete one cycle after acceptance.
module ex_muldiv_unit #(
   parameter int MUL_CYCLES = 3,
   parameter int DIV_ITERS  = 32
) (
   input  logic            clk,
   input  logic            reset,
   ex_muldiv_unit_if.slave mdu
);
   localparam int CNT_W = 6;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_ITERS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic [31:0]      rs_q, rs_d;
   logic [31:0]      rt_q, rt_d;
   logic [31:0]      rem_q, rem_d;
   logic [31:0]      quo_q, quo_d;
   logic [31:0]      dvs_q, dvs_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             busy_q;
   logic             done_q, done_d;

   logic        accept;
   logic        in_sgn;
   logic [31:0] rs_mag, rt_mag;
   logic        mul_sgn;
   logic [31:0] mul_a, mul_b;
   logic [63:0] prod;
   logic [32:0] rem_sh;
   logic        rem_ge;
   logic [31:0] quo_fix, rem_fix;

   assign accept = (state_q == S_IDLE) && mdu.start_ex_muldiv_i && !mdu.flush_ex_muldiv_i;
   assign in_sgn = ~mdu.op_ex_muldiv_i[0];
   assign rs_mag = (in_sgn && mdu.rs_data_ex_muldiv_i[31]) ? -mdu.rs_data_ex_muldiv_i
                                                            :  mdu.rs_data_ex_muldiv_i;
   assign rt_mag = (in_sgn && mdu.rt_data_ex_muldiv_i[31]) ? -mdu.rt_data_ex_muldiv_i
                                                            :  mdu.rt_data_ex_muldiv_i;

   // Single multiplier; the port operands feed it directly only for the one-cycle configuration.
   assign mul_sgn = (state_q == S_IDLE) ? in_sgn : sgn_q;
   assign mul_a   = (state_q == S_IDLE) ? mdu.rs_data_ex_muldiv_i : rs_q;
   assign mul_b   = (state_q == S_IDLE) ? mdu.rt_data_ex_muldiv_i : rt_q;
   assign prod    = {{32{mul_sgn & mul_a[31]}}, mul_a} * {{32{mul_sgn & mul_b[31]}}, mul_b};

   assign rem_sh  = {rem_q, quo_q[31]};
   assign rem_ge  = rem_sh >= {1'b0, dvs_q};
   assign quo_fix = (sgn_q && (rs_q[31] ^ rt_q[31])) ? -quo_q : quo_q;
   assign rem_fix = (sgn_q && rs_q[31]) ? -rem_q : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sgn_d = in_sgn;
               rs_d  = mdu.rs_data_ex_muldiv_i;
               rt_d  = mdu.rt_data_ex_muldiv_i;
               case (mdu.op_ex_muldiv_i)
                  OP_MULT, OP_MULTU: begin
                     if (MUL_CYCLES == 1) begin
                        {hi_d, lo_d} = prod;
                        done_d       = 1'b1;
                     end else begin
                        state_d = S_MUL;
                        cnt_d   = MUL_LOAD;
                     end
                  end
                  OP_DIV, OP_DIVU: begin
`ifdef MULDIV_EARLY_OUT_EN
                     if ((mdu.rt_data_ex_muldiv_i == '0) || (rs_mag < rt_mag)) begin
                        hi_d   = mdu.rs_data_ex_muldiv_i;
                        lo_d   = (mdu.rt_data_ex_muldiv_i == '0) ? '1 : '0;
                        done_d = 1'b1;
                     end else
`endif
                     begin
                        rem_d   = '0;
                        quo_d   = rs_mag;
                        dvs_d   = rt_mag;
                        cnt_d   = DIV_LOAD;
                        state_d = S_DIV;
                     end
                  end
                  OP_MTHI: hi_d = mdu.rs_data_ex_muldiv_i;
                  OP_MTLO: lo_d = mdu.rs_data_ex_muldiv_i;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (mdu.flush_ex_muldiv_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            // The acceptance cycle is the first of the MUL_CYCLES, so the count expires one early.
            end else if (cnt_q <= CNT_ONE) begin
               {hi_d, lo_d} = prod;
               done_d       = 1'b1;
               cnt_d        = '0;
               state_d      = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DIV: begin
            if (mdu.flush_ex_muldiv_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               rem_d = rem_ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
               quo_d = {quo_q[30:0], rem_ge};
               if (cnt_q == '0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!mdu.flush_ex_muldiv_i) begin
               done_d = 1'b1;
               if (dvs_q == '0) begin
                  lo_d = '1;
                  hi_d = rs_q;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
      end
   end

   assign mdu.busy_ex_muldiv_o = busy_q;
   assign mdu.done_ex_muldiv_o = done_q;
   assign mdu.hi_ex_muldiv_o   = hi_q;
   assign mdu.lo_ex_muldiv_o   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, corner sequences and randomized ops vs. an arithmetic model.
module tb_ex_muldiv_unit;
   localparam int MUL_CYC = 3;
   localparam int DIV_IT  = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_muldiv_unit_if ifc ();

   ex_muldiv_unit #(.MUL_CYCLES(MUL_CYC), .DIV_ITERS(DIV_IT)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (ifc)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t        vecs [11];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] hi_m, lo_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Architectural result of one instruction, from plain integer arithmetic.
   function automatic void model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in,
                                 output logic [31:0] hi_o, output logic [31:0] lo_o);
      longint      sa, sb;
      logic [63:0] p;
      sa   = longint'($signed(rs));
      sb   = longint'($signed(rt));
      hi_o = hi_in;
      lo_o = lo_in;
      case (op)
         3'd0: begin p = 64'(sa * sb); hi_o = p[63:32]; lo_o = p[31:0]; end
         3'd1: begin p = {32'd0, rs} * {32'd0, rt}; hi_o = p[63:32]; lo_o = p[31:0]; end
         3'd2: begin
            if (rt == 0) begin hi_o = rs; lo_o = 32'hFFFF_FFFF; end
            else begin lo_o = 32'(sa / sb); hi_o = 32'(sa % sb); end
         end
         3'd3: begin
            if (rt == 0) begin hi_o = rs; lo_o = 32'hFFFF_FFFF; end
            else begin lo_o = rs / rt; hi_o = rs % rt; end
         end
         3'd4: hi_o = rs;
         3'd5: lo_o = rs;
         default: ;
      endcase
   endfunction

   // Cycle (counting the acceptance cycle as 0) in which done is expected; 0 = no done pulse.
   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      longint ma, mb;
      if (op <= 3'd1) return MUL_CYC;
      if (op >= 3'd4) return 0;
      if (op == 3'd2) begin
         ma = longint'($signed(rs)); if (ma < 0) ma = -ma;
         mb = longint'($signed(rt)); if (mb < 0) mb = -mb;
      end else begin
         ma = longint'({32'd0, rs});
         mb = longint'({32'd0, rt});
      end
      if (EARLY && (mb == 0 || ma < mb)) return 1;
      return DIV_IT + 2;
   endfunction

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                         input bit hammer);
      int lat;
      lat = exp_lat(op, rs, rt);
      ifc.start_ex_muldiv_i   = 1'b1;
      ifc.op_ex_muldiv_i      = op;
      ifc.rs_data_ex_muldiv_i = rs;
      ifc.rt_data_ex_muldiv_i = rt;
      step();
      ifc.start_ex_muldiv_i   = 1'b0;
      ifc.op_ex_muldiv_i      = 3'($urandom_range(0, 5));
      ifc.rs_data_ex_muldiv_i = $urandom;
      ifc.rt_data_ex_muldiv_i = $urandom;
      if (lat == 0) begin
         chk({name, "_busy"}, 64'(ifc.busy_ex_muldiv_o), 64'd0);
         chk({name, "_done"}, 64'(ifc.done_ex_muldiv_o), 64'd0);
      end else begin
         for (int k = 1; k <= lat; k++) begin
            if (k > 1) step();
            chk({name, "_busy"}, 64'(ifc.busy_ex_muldiv_o), 64'(k < lat));
            chk({name, "_done"}, 64'(ifc.done_ex_muldiv_o), 64'(k == lat));
            if (hammer && k >= 2 && k <= 5 && k < lat) begin
               ifc.start_ex_muldiv_i   = 1'b1;
               ifc.op_ex_muldiv_i      = 3'd1;
               ifc.rs_data_ex_muldiv_i = $urandom;
            end else begin
               ifc.start_ex_muldiv_i = 1'b0;
            end
         end
      end
      chk({name, "_hi"}, 64'(ifc.hi_ex_muldiv_o), 64'(ehi));
      chk({name, "_lo"}, 64'(ifc.lo_ex_muldiv_o), 64'(elo));
      if (lat != 0) begin
         step();
         chk({name, "_done_once"}, 64'(ifc.done_ex_muldiv_o), 64'd0);
      end
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 15));
         1:       return -32'($urandom_range(1, 15));
         2:       return $urandom & 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  op;
      logic [31:0] rs, rt, ehi, elo;

      vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1]  = '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14};
      vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{3'd3, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
      vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
      vecs[5]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
      vecs[7]  = '{3'd2, 32'd0,         32'd0,        32'd0,         32'hFFFF_FFFF};
      vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
      vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF};
      vecs[10] = '{3'd2, 32'd3,         32'hFFFF_FFF6, 32'd3,        32'd0};

      reset                   = 1'b1;
      ifc.start_ex_muldiv_i   = 1'b0;
      ifc.op_ex_muldiv_i      = 3'd0;
      ifc.rs_data_ex_muldiv_i = '0;
      ifc.rt_data_ex_muldiv_i = '0;
      ifc.flush_ex_muldiv_i   = 1'b0;
      hi_m = '0;
      lo_m = '0;
      repeat (2) step();
      chk("rst_hi",   64'(ifc.hi_ex_muldiv_o),   64'd0);
      chk("rst_lo",   64'(ifc.lo_ex_muldiv_o),   64'd0);
      chk("rst_busy", 64'(ifc.busy_ex_muldiv_o), 64'd0);
      chk("rst_done", 64'(ifc.done_ex_muldiv_o), 64'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                vecs[i].hi, vecs[i].lo, (i % 2) == 1);
         hi_m = vecs[i].hi;
         lo_m = vecs[i].lo;
      end

      run_op("mthi", 3'd4, 32'hDEAD_BEEF, 32'd9, 32'hDEAD_BEEF, lo_m, 1'b0);
      hi_m = 32'hDEAD_BEEF;
      run_op("mtlo", 3'd5, 32'h1234_5678, 32'd9, hi_m, 32'h1234_5678, 1'b0);
      lo_m = 32'h1234_5678;

      // Flush one cycle into a MULTU: HI/LO untouched, no done.
      ifc.start_ex_muldiv_i   = 1'b1;
      ifc.op_ex_muldiv_i      = 3'd1;
      ifc.rs_data_ex_muldiv_i = 32'd2;
      ifc.rt_data_ex_muldiv_i = 32'd3;
      step();
      ifc.start_ex_muldiv_i = 1'b0;
      chk("flush_busy_c1", 64'(ifc.busy_ex_muldiv_o), 64'd1);
      ifc.flush_ex_muldiv_i = 1'b1;
      step();
      ifc.flush_ex_muldiv_i = 1'b0;
      chk("flush_busy_after", 64'(ifc.busy_ex_muldiv_o), 64'd0);
      for (int k = 0; k < 4; k++) begin
         chk("flush_no_done", 64'(ifc.done_ex_muldiv_o), 64'd0);
         step();
      end
      chk("flush_hi", 64'(ifc.hi_ex_muldiv_o), 64'hDEAD_BEEF);
      chk("flush_lo", 64'(ifc.lo_ex_muldiv_o), 64'h1234_5678);

      // Start together with flush is never accepted.
      ifc.start_ex_muldiv_i   = 1'b1;
      ifc.flush_ex_muldiv_i   = 1'b1;
      ifc.op_ex_muldiv_i      = 3'd0;
      ifc.rs_data_ex_muldiv_i = 32'd7;
      ifc.rt_data_ex_muldiv_i = 32'd7;
      step();
      ifc.start_ex_muldiv_i = 1'b0;
      ifc.flush_ex_muldiv_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("sflush_busy", 64'(ifc.busy_ex_muldiv_o), 64'd0);
         chk("sflush_done", 64'(ifc.done_ex_muldiv_o), 64'd0);
         step();
      end
      chk("sflush_hi", 64'(ifc.hi_ex_muldiv_o), 64'(hi_m));
      chk("sflush_lo", 64'(ifc.lo_ex_muldiv_o), 64'(lo_m));

      run_op("div_hammer", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
      hi_m = 32'd2;
      lo_m = 32'd14;

      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 5));
         rs = rnd_opnd();
         rt = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_opnd();
         model(op, rs, rt, hi_m, lo_m, ehi, elo);
         run_op($sformatf("rnd%0d_op%0d", n, op), op, rs, rt, ehi, elo, $urandom_range(0, 1) == 1);
         hi_m = ehi;
         lo_m = elo;
      end

      // Reset in the middle of a divide clears everything.
      run_op("pre_rst_hi", 3'd4, 32'h1111_1111, 32'd0, 32'h1111_1111, lo_m, 1'b0);
      run_op("pre_rst_lo", 3'd5, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);
      ifc.start_ex_muldiv_i   = 1'b1;
      ifc.op_ex_muldiv_i      = 3'd3;
      ifc.rs_data_ex_muldiv_i = 32'd1000;
      ifc.rt_data_ex_muldiv_i = 32'd3;
      step();
      ifc.start_ex_muldiv_i = 1'b0;
      repeat (9) step();
      chk("mid_div_busy", 64'(ifc.busy_ex_muldiv_o), 64'd1);
      reset = 1'b1;
      #1;
      chk("arst_hi",   64'(ifc.hi_ex_muldiv_o),   64'd0);
      chk("arst_busy", 64'(ifc.busy_ex_muldiv_o), 64'd0);
      step();
      chk("rst_div_hi",   64'(ifc.hi_ex_muldiv_o),   64'd0);
      chk("rst_div_lo",   64'(ifc.lo_ex_muldiv_o),   64'd0);
      chk("rst_div_busy", 64'(ifc.busy_ex_muldiv_o), 64'd0);
      chk("rst_div_done", 64'(ifc.done_ex_muldiv_o), 64'd0);
      reset = 1'b0;
      repeat (3) step();
      chk("post_rst_done", 64'(ifc.done_ex_muldiv_o), 64'd0);
      chk("post_rst_busy", 64'(ifc.busy_ex_muldiv_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
